rv_div_unit: RTL
================

# rv_div_unit

Parametrised iterative integer divider for the RV32IM execute stage, implementing DIV/DIVU/REM/REMU with RISC-V semantics. Operands enter over a valid/ready handshake, and the result leaves over a second one with an opaque tag (rd/pc/inst). This replaces fixed-latency stall counting with handshake-based completion, configurable bits-per-cycle, a single-cycle fast path for special cases, and a synchronous flush for branch redirects.

## Interface
- XLEN, 32, operand/result width; must be a multiple of UNROLL.
- UNROLL, 1, quotient bits retired per CALC cycle; legal values are 1, 2, 4.
- TAG_W, 69, width of the pass-through tag (e.g. rd 5 + pc 32 + inst 32).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight or held operation.
- in_valid  in  1  operation request.
- in_ready  out  1  divider can accept the request this cycle.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- in_a  in  XLEN  dividend (rs1).
- in_b  in  XLEN  divisor (rs2).
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  XLEN  quotient or remainder, selected by op.
- out_tag  out  TAG_W  tag captured at accept.
- busy  out  1  high in CALC or FIX; the hazard unit uses it to stall younger M-ext ops.

## Operation
- An accept happens on a rising edge where in_valid && in_ready && !flush. On accept, op, tag, operand signs and operand magnitudes (absolute values for signed ops) are latched.
- States:
  - IDLE: in_ready=1.
  - CALC: restoring shift-subtract, UNROLL bits per cycle, iteration counter counts down from XLEN/UNROLL.
  - FIX: apply signs. Quotient is negated if the operand signs differ (signed ops). Remainder takes the dividend's sign.
  - DONE: out_valid=1, outputs held stable.
- Transitions:
  - IDLE→CALC on accept of a normal operation.
  - IDLE→DONE on accept of a special case (fast path).
  - CALC→FIX when the counter reaches 0.
  - FIX→DONE unconditionally.
  - DONE→IDLE on out_ready with no new accept.
  - DONE→CALC or DONE on out_ready with a simultaneous accept (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Special cases (fast path, no CALC):
  - Divisor 0: quotient = all ones, remainder = in_a.
  - Signed overflow (in_a = 1<<(XLEN-1), in_b = all ones, op DIV or REM): quotient = in_a, remainder = 0.
  - Unsigned ops with in_b=0 follow the same divisor-0 rule.
- flush has the highest priority. The next state is IDLE and out_valid deasserts the next cycle. A request presented in the same cycle as flush is not accepted.
- Asynchronous reset mid-operation aborts it; no partial result is ever emitted.
- Internal datapath: remainder register XLEN+1 bits, quotient register XLEN bits. The result is truncated to XLEN.

## Timing
- Reset values:
  - State IDLE; in_ready=1.
  - out_valid=0, busy=0.
  - out_result=0, out_tag=0.
  - Counter and datapath registers 0.
- Normal latency, with N = XLEN/UNROLL: out_valid rises N+2 cycles after the accepting edge (N CALC cycles + 1 FIX cycle + entry to DONE).
  - XLEN=32, UNROLL=1: 34 cycles.
  - XLEN=32, UNROLL=4: 10 cycles.
- Fast-path latency: out_valid rises 1 cycle after the accepting edge.
- busy is high in exactly the CALC and FIX cycles: N+1 cycles per normal op, 0 for the fast path.
- out_valid is held with out_result and out_tag stable until the edge where out_ready=1. No combinational path from in_* to out_*.
- Throughput with out_ready tied high: one result every N+2 cycles, with no IDLE bubble between ops.

## Test plan
- Reset/idle: hold rst_n low, then release; check in_ready=1, out_valid=0, out_result=0. Assert rst_n low during CALC; check the next state is IDLE and no out_valid pulse occurs.
- Signed arithmetic (XLEN=32, UNROLL=1):
  - DIV -7/2 → 0xFFFFFFFD, out_valid exactly 34 cycles after accept.
  - REM -7%2 → 0xFFFFFFFF.
  - REM 7%-2 → 1.
  - Tag returned unchanged.
- Unsigned and UNROLL=4: DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF and REMU → 0xF, with latency 10; busy high for exactly 9 cycles.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - All four with 1-cycle latency and busy never high.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE; outputs stay stable and in_ready=0.
  - Raise out_ready with in_valid=1 on a new op; the new op is accepted on that same edge and the second result arrives 34 cycles later.
- Flush:
  - Assert flush mid-CALC with in_valid=1; next cycle state is IDLE, busy=0, out_valid never rises, and the new request is not accepted.
  - Flush in DONE drops the held result.

Source files
------------

// File: rtl/rv_div_if.sv
`timescale 1ns/1ps
// Request/response channel between the execute stage and the iterative divider.
// The request side carries operands and a tag; the response side returns the result with that tag.
interface rv_div_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 69
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/rv_div_unit.sv
`timescale 1ns/1ps
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring shift-subtract on magnitudes,
// UNROLL quotient bits per cycle, sign fix-up, and a one-cycle path for div-by-zero/overflow.
module rv_div_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 69
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  output logic    busy,
  rv_div_if.slave dif
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  localparam logic [XLEN-1:0] ONE    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL1   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MINNEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_N  = CW'(N);
  localparam logic [CW-1:0]   CNT_1  = CW'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             rem_op_q, rem_op_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic            in_ready_s, accept_s;
  logic            sgn_op_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic            div0_s, ovf_s, fast_s;
  logic [XLEN-1:0] fast_res_s;
  logic [XLEN:0]   rem_nx_s;
  logic [XLEN-1:0] quo_nx_s;
  logic [XLEN-1:0] quo_fix_s, rem_fix_s;

  assign in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && dif.out_ready);
  assign accept_s   = dif.in_valid && in_ready_s && !flush;

  assign sgn_op_s = !dif.in_op[0];
  assign a_neg_s  = sgn_op_s && dif.in_a[XLEN-1];
  assign b_neg_s  = sgn_op_s && dif.in_b[XLEN-1];
  assign a_mag_s  = a_neg_s ? (~dif.in_a + ONE) : dif.in_a;
  assign b_mag_s  = b_neg_s ? (~dif.in_b + ONE) : dif.in_b;

  assign div0_s = (dif.in_b == ZERO);
  assign ovf_s  = sgn_op_s && (dif.in_a == MINNEG) && (dif.in_b == ALL1);
  assign fast_s = div0_s || ovf_s;

  // Special-case results; divide-by-zero wins over overflow since its divisor test is exclusive anyway.
  always_comb begin
    fast_res_s = ZERO;
    if (div0_s) begin
      fast_res_s = dif.in_op[1] ? dif.in_a : ALL1;
    end else begin
      fast_res_s = dif.in_op[1] ? ZERO : dif.in_a;
    end
  end

  // UNROLL restoring steps; the remainder stays below 2*divisor so XLEN+1 bits suffice.
  always_comb begin
    rem_nx_s = rem_q;
    quo_nx_s = quo_q;
    for (int i = 0; i < UNROLL; i++) begin
      rem_nx_s = {rem_nx_s[XLEN-1:0], quo_nx_s[XLEN-1]};
      quo_nx_s = {quo_nx_s[XLEN-2:0], 1'b0};
      if (rem_nx_s >= {1'b0, dvs_q}) begin
        rem_nx_s    = rem_nx_s - {1'b0, dvs_q};
        quo_nx_s[0] = 1'b1;
      end else begin
        quo_nx_s[0] = 1'b0;
      end
    end
  end

  assign quo_fix_s = negq_q ? (~quo_q + ONE) : quo_q;
  assign rem_fix_s = negr_q ? (~rem_q[XLEN-1:0] + ONE) : rem_q[XLEN-1:0];

  // Next-state and datapath update; flush overrides everything, accept overrides the per-state step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_op_d = rem_op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    res_d    = res_q;
    tag_d    = tag_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept_s) begin
      rem_op_d = dif.in_op[1];
      tag_d    = dif.in_tag;
      negq_d   = a_neg_s ^ b_neg_s;
      negr_d   = a_neg_s;
      dvs_d    = b_mag_s;
      quo_d    = a_mag_s;
      rem_d    = {(XLEN+1){1'b0}};
      if (fast_s) begin
        res_d   = fast_res_s;
        cnt_d   = {CW{1'b0}};
        state_d = S_DONE;
      end else begin
        cnt_d   = CNT_N;
        state_d = S_CALC;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CALC: begin
          rem_d = rem_nx_s;
          quo_d = quo_nx_s;
          cnt_d = cnt_q - CNT_1;
          if (cnt_q == CNT_1) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
        S_FIX: begin
          res_d   = rem_op_q ? rem_fix_s : quo_fix_s;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (dif.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      rem_q    <= {(XLEN+1){1'b0}};
      quo_q    <= ZERO;
      dvs_q    <= ZERO;
      rem_op_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      res_q    <= ZERO;
      tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_op_q <= rem_op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
    end
  end

  assign dif.in_ready   = in_ready_s;
  assign dif.out_valid  = (state_q == S_DONE);
  assign dif.out_result = res_q;
  assign dif.out_tag    = tag_q;
  assign busy           = (state_q == S_CALC) || (state_q == S_FIX);

endmodule
